// File: rtl/ext_mem_boot_port.sv
// ext_mem_boot_port
// -----------------------------------------------------------------------------
// Synthesizable external-memory front end. A DEPTH-word array is preloaded
// through the init port while IDLE. A boot pulse then streams BOOT_LEAD
// zero-data tokens followed by BOOT_LEN memory words into the load channel.
// After boot the block sits in SERVE: it answers load requests through a
// LD_LATENCY-deep pipeline and commits store requests.
//
// Token layouts (MSB first):
//   FTk : {v, a, r, c, i[WIDTH_EXADDR-1:0], d[WIDTH_DATA-1:0]}
//   BTk : {n, t, v, c}   only n is meaningful here (stall / refuse)
//
// Handshake: a load token on O_Ld_FTk is consumed at a rising edge where
// O_Ld_FTk.v=1 and I_Ld_BTk.n=0; while n=1 the token is held unchanged.
// A load request is accepted at an edge where I_Ld_Req=1 and O_Ld_Rdy=1.
// A store commits at an edge where I_St_Req=1, I_St_FTk.v=1 and
// O_St_BTk.n=0.
//
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   I_Boot                   boot start (only looked at in IDLE)
//   I_Init_We/Addr/Data      preload write port (only honoured in IDLE)
//   I_Ld_Req/Addr, O_Ld_Rdy  load request channel
//   O_Ld_FTk, I_Ld_BTk       load data token and its back-token
//   I_St_Req/Addr, I_St_FTk  store request channel
//   O_St_BTk                 store back-token (n=1 means refused)
//   O_Busy                   high while booting
//   O_Err                    sticky out-of-range access flag
//   O_Ld_Cnt, O_St_Cnt       accepted loads / committed stores (wrapping)
//   O_Dbg_State              FSM state: 0 IDLE, 1 BOOT, 2 SERVE
// LD_LATENCY must lie in 1..4.
// -----------------------------------------------------------------------------
module ext_mem_boot_port #(
  parameter int DEPTH        = 1024,
  parameter int BOOT_LEAD    = 3,
  parameter int BOOT_LEN     = 5,
  parameter int BOOT_BASE    = 0,
  parameter int LD_LATENCY   = 1,
  parameter int INDEX_MODE   = 0,
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_EXADDR = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 I_Boot,
  input  logic                                 I_Init_We,
  input  logic [WIDTH_EXADDR-1:0]              I_Init_Addr,
  input  logic [WIDTH_DATA-1:0]                I_Init_Data,
  input  logic                                 I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0]              I_Ld_Addr,
  output logic                                 O_Ld_Rdy,
  output logic [WIDTH_EXADDR+WIDTH_DATA+3:0]   O_Ld_FTk,
  input  logic [3:0]                           I_Ld_BTk,
  input  logic                                 I_St_Req,
  input  logic [WIDTH_EXADDR-1:0]              I_St_Addr,
  input  logic [WIDTH_EXADDR+WIDTH_DATA+3:0]   I_St_FTk,
  output logic [3:0]                           O_St_BTk,
  output logic                                 O_Busy,
  output logic                                 O_Err,
  output logic [15:0]                          O_Ld_Cnt,
  output logic [15:0]                          O_St_Cnt,
  output logic [1:0]                           O_Dbg_State
);

  localparam int          FTK_W    = WIDTH_EXADDR + WIDTH_DATA + 4;
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          BOOT_TOT = BOOT_LEAD + BOOT_LEN;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [15:0] K_LAST   = 16'(BOOT_TOT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BOOT  = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [15:0] k_q, k_d;
  logic        err_q;
  logic [15:0] ld_cnt_q, st_cnt_q;

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [FTK_W-1:0]      pipe_q [LD_LATENCY];

  // Back-token bits other than n, and store-token fields other than v/d,
  // carry nothing this block needs.
  logic unused_bits;
  assign unused_bits = ^{I_Ld_BTk[2:0], I_St_FTk[FTK_W-2:WIDTH_DATA]};

  logic ld_stall;
  logic in_boot, in_serve, in_idle;
  assign ld_stall = I_Ld_BTk[3];
  assign in_idle  = (state_q == S_IDLE);
  assign in_boot  = (state_q == S_BOOT);
  assign in_serve = (state_q == S_SERVE);

  // ---------------- range checks ----------------
  logic init_ok, ld_ok, st_ok, boot_ok;
  logic [31:0] boot_addr;
  assign init_ok   = 32'(I_Init_Addr) < DEPTH_U;
  assign ld_ok     = 32'(I_Ld_Addr)   < DEPTH_U;
  assign st_ok     = 32'(I_St_Addr)   < DEPTH_U;
  assign boot_addr = 32'(BOOT_BASE) + 32'(k_q) - 32'(BOOT_LEAD);
  assign boot_ok   = boot_addr < DEPTH_U;

  // ---------------- load channel ----------------
  logic                    ld_adv, ld_acc;
  logic [WIDTH_DATA-1:0]   ld_data;
  logic [WIDTH_EXADDR-1:0] ld_idx;
  logic [FTK_W-1:0]        ld_tok;

  assign ld_adv  = in_serve & ~ld_stall;
  assign ld_acc  = I_Ld_Req & ld_adv;
  // Combinational read in the acceptance cycle; a store to the same
  // address lands at the edge, so the load sees the old word.
  assign ld_data = ld_ok ? mem[I_Ld_Addr[AW-1:0]] : '0;
  assign ld_idx  = (INDEX_MODE != 0) ? I_Ld_Addr : '0;
  assign ld_tok  = {1'b1, 1'b0, 1'b0, 1'b0, ld_idx, ld_data};

  // ---------------- boot token ----------------
  logic                  boot_lead;
  logic [WIDTH_DATA-1:0] boot_data;
  logic [FTK_W-1:0]      boot_tok;

  assign boot_lead = 32'(k_q) < 32'(BOOT_LEAD);
  assign boot_data = (boot_lead || !boot_ok) ? '0 : mem[boot_addr[AW-1:0]];
  assign boot_tok  = {1'b1, (k_q == 16'd0), 1'b0, 1'b0,
                      {WIDTH_EXADDR{1'b0}}, boot_data};

  // ---------------- memory write port / error sources ----------------
  // Init writes are only possible in IDLE and stores only in SERVE, so one
  // write port serves both.
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [WIDTH_DATA-1:0]   mem_wdata;
  logic                    st_commit;
  logic                    err_set;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    st_commit = 1'b0;
    err_set   = 1'b0;
    if (in_idle && I_Init_We) begin
      if (init_ok) begin
        mem_we    = 1'b1;
        mem_waddr = I_Init_Addr[AW-1:0];
        mem_wdata = I_Init_Data;
      end else begin
        err_set = 1'b1;
      end
    end
    if (in_serve && I_St_Req && I_St_FTk[FTK_W-1]) begin
      if (st_ok) begin
        mem_we    = 1'b1;
        mem_waddr = I_St_Addr[AW-1:0];
        mem_wdata = I_St_FTk[WIDTH_DATA-1:0];
        st_commit = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
    if (ld_acc && !ld_ok) begin
      err_set = 1'b1;
    end
  end

  // Memory has no reset: contents survive a reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (I_Boot) begin
          state_d = S_BOOT;
          k_d     = 16'd0;
        end
      end
      S_BOOT: begin
        if (!ld_stall) begin
          if (k_q == K_LAST) begin
            state_d = S_SERVE;
          end else begin
            k_d = k_q + 16'd1;
          end
        end
      end
      S_SERVE: begin
        state_d = S_SERVE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= 16'd0;
      err_q    <= 1'b0;
      ld_cnt_q <= 16'd0;
      st_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (ld_acc) begin
        ld_cnt_q <= ld_cnt_q + 16'd1;
      end
      if (st_commit) begin
        st_cnt_q <= st_cnt_q + 16'd1;
      end
    end
  end

  // Load pipeline: shifts only while the consumer is not stalling, so the
  // last stage (the visible token) holds during back-pressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < LD_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else if (ld_adv) begin
      pipe_q[0] <= ld_acc ? ld_tok : '0;
      for (int s = 1; s < LD_LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    O_Ld_FTk = '0;
    if (in_boot) begin
      O_Ld_FTk = boot_tok;
    end else if (in_serve) begin
      O_Ld_FTk = pipe_q[LD_LATENCY-1];
    end
  end

  assign O_Ld_Rdy    = ld_adv;
  assign O_St_BTk    = {~in_serve, 3'b000};
  assign O_Busy      = in_boot;
  assign O_Err       = err_q;
  assign O_Ld_Cnt    = ld_cnt_q;
  assign O_St_Cnt    = st_cnt_q;
  assign O_Dbg_State = state_q;

endmodule
